round_timer: RTL and testbench

//  Multi-digit BCD countdown timer for the game round clock; the count-down counterpart of the score/up-counter chain.

---
 rtl/round_timer_pkg.sv | 37 +++
 rtl/round_timer_decimal_down_unit.sv | 37 +++
 rtl/round_timer.sv | 106 ++++++++++
 tb/tb_round_timer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/round_timer_pkg.sv
// rtl/round_timer_pkg.sv - shared state encoding, BCD constants and nibble helpers for round_timer
package round_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } rt_state_e;

  localparam logic [3:0] BCD_MAX  = 4'h9;
  localparam logic [3:0] BCD_ZERO = 4'h0;

  function automatic logic [3:0] clamp_nibble(input logic [3:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

  // Packed-BCD decrement over the widest supported value (6 digits); callers zero-pad.
  function automatic logic [23:0] bcd_dec24(input logic [23:0] v);
    logic [23:0] r;
    logic        brw;
    r   = v;
    brw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (brw) begin
        if (v[4*i +: 4] == BCD_ZERO) begin
          r[4*i +: 4] = BCD_MAX;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          brw         = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/round_timer_decimal_down_unit.sv
// rtl/round_timer_decimal_down_unit.sv - one BCD down-digit with load clamp and borrow output
module decimal_down_unit
  import round_timer_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] value,
  output logic       borrow_out
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = clamp_nibble(load_digit);
    end else if (enable) begin
      value_d = (value_q == BCD_ZERO) ? BCD_MAX : value_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      value_q <= BCD_ZERO;
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign borrow_out = enable && (value_q == BCD_ZERO);

endmodule

// File: rtl/round_timer.sv
// rtl/round_timer.sv - BCD countdown round timer; optional warn output under ROUND_TIMER_WARN_EN
module round_timer
  import round_timer_pkg::*;
#(
  parameter int                        NUM_DIGITS = 3,
  parameter logic [4*NUM_DIGITS-1:0]   WARN_BCD   = 12'h010
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    tick,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    expired,
  output logic                    time_up,
  output logic                    warn
);

  localparam logic [4*NUM_DIGITS-1:0] VAL_ZERO = '0;
  localparam logic [4*NUM_DIGITS-1:0] VAL_ONE  = (4*NUM_DIGITS)'(1);

  rt_state_e               state_q, state_d;
  logic                    running_q, expired_q, time_up_q, time_up_d;
  logic [NUM_DIGITS:0]     en;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic                    count_en;

  // Counting only happens in RUNNING with a nonzero value, so the chain never underflows.
  assign count_en = !load && (state_q == ST_RUNNING) && !pause && tick;
  assign en[0]    = count_en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    decimal_down_unit u_digit (
      .clock      (clock),
      .resetn     (resetn),
      .enable     (en[g]),
      .load       (load),
      .load_digit (load_value[4*g +: 4]),
      .value      (digits_q[4*g +: 4]),
      .borrow_out (en[g+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    time_up_d = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (start && digits_q != VAL_ZERO) state_d = ST_RUNNING;
        ST_RUNNING: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick && (digits_q == VAL_ONE || en[NUM_DIGITS])) begin
            state_d   = ST_EXPIRED;
            time_up_d = 1'b1;
          end
        end
        ST_PAUSED:  if (start) state_d = ST_RUNNING;
        default:    state_d = state_q;
      endcase
    end
  end

`ifdef ROUND_TIMER_WARN_EN
  logic                    warn_q, warn_d;
  logic [23:0]             dec_full;
  logic [4*NUM_DIGITS-1:0] digits_next;

  // Compare against the value the digits take at this edge so warn lines up with digits.
  assign dec_full    = bcd_dec24(24'(digits_q));
  assign digits_next = count_en ? dec_full[4*NUM_DIGITS-1:0] : digits_q;
  assign warn_d      = ((state_d == ST_RUNNING) || (state_d == ST_PAUSED)) &&
                       (digits_next <= WARN_BCD);
`else
  logic warn_q, warn_d;
  assign warn_d = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      time_up_q <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUNNING);
      expired_q <= (state_d == ST_EXPIRED);
      time_up_q <= time_up_d;
      warn_q    <= warn_d;
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign expired = expired_q;
  assign time_up = time_up_q;
  assign warn    = warn_q;

endmodule

// File: tb/tb_round_timer.sv
// tb/tb_round_timer.sv - directed self-checking bench for round_timer
module tb_round_timer;

  logic        clock = 1'b0;
  logic        resetn, tick, load, start, pause;
  logic [11:0] load_value;
  logic [11:0] digits;
  logic        running, expired, time_up, warn;

  int n_checks = 0;
  int n_fail   = 0;

  round_timer #(.NUM_DIGITS(3), .WARN_BCD(12'h010)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .digits     (digits),
    .running    (running),
    .expired    (expired),
    .time_up    (time_up),
    .warn       (warn)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1; load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_value = 12'h000;

    // reset
    step();
    chk("rst_digits", 32'(digits), 32'h000);
    chk("rst_running", 32'(running), 0);
    chk("rst_expired", 32'(expired), 0);
    chk("rst_time_up", 32'(time_up), 0);
    chk("rst_warn", 32'(warn), 0);
    resetn = 1'b1;

    // borrow across two digits
    do_load(12'h100);
    chk("t2_load", 32'(digits), 32'h100);
    chk("t2_idle", 32'(running), 0);
    pulse_start();
    chk("t2_running", 32'(running), 1);
    pulse_tick();
    chk("t2_digits", 32'(digits), 32'h099);
    chk("t2_still_running", 32'(running), 1);

    // countdown to zero
    do_load(12'h002);
    chk("t3_load_idle", 32'(running), 0);
    pulse_start();
    pulse_tick();
    chk("t3_001", 32'(digits), 32'h001);
    chk("t3_no_tu", 32'(time_up), 0);
    pulse_tick();
    chk("t3_000", 32'(digits), 32'h000);
    chk("t3_tu", 32'(time_up), 1);
    chk("t3_expired", 32'(expired), 1);
    chk("t3_not_running", 32'(running), 0);
    step();
    chk("t3_tu_clear", 32'(time_up), 0);
    chk("t3_expired_hold", 32'(expired), 1);
    tick = 1'b1; step(); step();
    chk("t3_hold_zero", 32'(digits), 32'h000);
    chk("t3_tu_quiet", 32'(time_up), 0);
    start = 1'b1; pause = 1'b1; step();
    start = 1'b0; pause = 1'b0; tick = 1'b0;
    chk("t3_exp_sticky", 32'(expired), 1);
    chk("t3_exp_digits", 32'(digits), 32'h000);

    // pause/resume
    do_load(12'h050);
    chk("t4_load_clears_exp", 32'(expired), 0);
    pulse_start();
    pause = 1'b1; tick = 1'b1; step();
    pause = 1'b0;
    chk("t4_paused_digits", 32'(digits), 32'h050);
    chk("t4_paused_running", 32'(running), 0);
    step(); step(); step();
    chk("t4_paused_ticks", 32'(digits), 32'h050);
    start = 1'b1; step();
    start = 1'b0;
    chk("t4_resume_running", 32'(running), 1);
    chk("t4_resume_no_dec", 32'(digits), 32'h050);
    step();
    tick = 1'b0;
    chk("t4_049", 32'(digits), 32'h049);

    // clamp, start on zero, load priority
    do_load(12'h0A5);
    chk("t5_clamp", 32'(digits), 32'h095);
    do_load(12'hF9F);
    chk("t5_clamp_all", 32'(digits), 32'h999);
    pulse_start();
    pulse_tick();
    chk("t5_998", 32'(digits), 32'h998);
    load = 1'b1; load_value = 12'h123; tick = 1'b1; step();
    load = 1'b0; tick = 1'b0;
    chk("t5_load_prio", 32'(digits), 32'h123);
    chk("t5_load_idle", 32'(running), 0);
    do_load(12'h000);
    pulse_start();
    chk("t5_zero_idle", 32'(running), 0);
    chk("t5_zero_no_tu", 32'(time_up), 0);
    pulse_tick();
    chk("t5_zero_digits", 32'(digits), 32'h000);
    chk("t5_zero_no_exp", 32'(expired), 0);
    chk("t5_zero_tu2", 32'(time_up), 0);

`ifdef ROUND_TIMER_WARN_EN
    do_load(12'h012);
    pulse_start();
    chk("t6_warn_012", 32'(warn), 0);
    pulse_tick();
    chk("t6_warn_011", 32'(warn), 0);
    pulse_tick();
    chk("t6_digits_010", 32'(digits), 32'h010);
    chk("t6_warn_010", 32'(warn), 1);
    pause = 1'b1; step(); pause = 1'b0;
    chk("t6_warn_paused", 32'(warn), 1);
    pulse_start();
    for (int i = 0; i < 10; i++) pulse_tick();
    chk("t6_expired", 32'(expired), 1);
    chk("t6_warn_exp", 32'(warn), 0);
    do_load(12'h005);
    chk("t6_warn_load", 32'(warn), 0);
    chk("t6_idle", 32'(running), 0);
    chk("t6_not_exp", 32'(expired), 0);
`else
    do_load(12'h003);
    pulse_start();
    pulse_tick();
    chk("t6_warn_tied", 32'(warn), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
